// File: rtl/tt_um_priority_decoder_if.sv
// Pin bundle of the priority decoder: host-side control/index byte in,
// registered one-hot mask bytes and the uio direction mask out.
interface tt_um_priority_decoder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_priority_decoder.sv
// Inverse of the 16-input priority encoder: a strobed index is turned back into
// a registered one-hot (replace) or OR-accumulated mask, driven as {uo_out, uio_out}.
module tt_um_priority_decoder (
  input logic                     clk,
  input logic                     rst_n,
  tt_um_priority_decoder_if.slave bus
);

  logic [7:0]  s1;
  logic [7:0]  s2;
  logic        stb_q;
  logic [15:0] mask;
  logic        evt;
  logic [15:0] onehot;
  logic        unused_inputs;

  always_comb begin
    evt    = s2[4] & ~stb_q;
    onehot = 16'h0001 << s2[3:0];
  end

  // Clear outranks any coincident event; stb_q still tracks so that edge is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 8'h00;
      s2    <= 8'h00;
      stb_q <= 1'b0;
      mask  <= 16'h0000;
    end else begin
      s1    <= bus.ui_in;
      s2    <= s1;
      stb_q <= s2[4];
      if (s2[6]) begin
        mask <= 16'h0000;
      end else if (evt) begin
        if (s2[7]) begin
          if (!s2[5]) begin
            mask <= 16'h0000;
          end
        end else if (s2[5]) begin
          mask <= mask | onehot;
        end else begin
          mask <= onehot;
        end
      end
    end
  end

  assign bus.uo_out  = mask[15:8];
  assign bus.uio_out = mask[7:0];
  assign bus.uio_oe  = 8'hFF;

  assign unused_inputs = &{1'b0, bus.ena, bus.uio_in};

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Scoreboard bench for tt_um_priority_decoder: events push the spec-model mask,
// each scenario task pops and compares once the 3-edge latency has elapsed.
module tb_tt_um_priority_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [15:0] model_mask;
  logic [15:0] prev_mask;
  logic [15:0] exp_q[$];

  tt_um_priority_decoder_if dut_if ();

  tt_um_priority_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_next(input logic [15:0] m, input logic [3:0] idx,
                                             input logic acc, input logic none);
    if (none) return acc ? m : 16'h0000;
    return acc ? (m | (16'h0001 << idx)) : (16'h0001 << idx);
  endfunction

  // Reference priority encoder: highest set bit wins, 8'hF0 means no input.
  function automatic logic [7:0] encode(input logic [15:0] m);
    logic [7:0] r;
    r = 8'hF0;
    for (int i = 0; i < 16; i++) if (m[i]) r = 8'(i);
    return r;
  endfunction

  function automatic logic [15:0] next_expected();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  function automatic logic [15:0] dut_mask();
    return {dut_if.uo_out, dut_if.uio_out};
  endfunction

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one stb pulse and returns just after edge k+1, one edge before the mask moves.
  task automatic send_event(input logic [3:0] idx, input logic acc, input logic none);
    dut_if.ui_in = {none, 1'b0, acc, 1'b0, idx};
    settle(1);
    dut_if.ui_in[4] = 1'b1;
    settle(1);
    dut_if.ui_in[4] = 1'b0;
    settle(1);
    prev_mask  = model_mask;
    model_mask = model_next(model_mask, idx, acc, none);
    exp_q.push_back(model_mask);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0;
    dut_if.ui_in = 8'hFF;
    settle(2);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_mask: got %h expected 0000", got);
    end
    checks++;
    if (dut_if.uio_oe !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_oe: got %h expected ff", dut_if.uio_oe);
    end
    rst_n = 1'b1;
    settle(5);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL release_stb_held_clr: got %h expected 0000", got);
    end
    dut_if.ui_in = 8'h00;
    settle(4);
    model_mask = 16'h0000;
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL release_idle: got %h expected 0000", got);
    end
  endtask

  task automatic test_replace_sweep();
    logic [15:0] got;
    logic [15:0] exp;
    logic [7:0]  enc;
    for (int i = 0; i < 16; i++) begin
      send_event(4'(i), 1'b0, 1'b0);
      checks++;
      got = dut_mask();
      if (got !== prev_mask) begin
        failures++;
        $display("[TB] FAIL replace_early idx=%0d: got %h expected %h", i, got, prev_mask);
      end
      settle(1);
      exp = next_expected();
      got = dut_mask();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL replace idx=%0d: got %h expected %h", i, got, exp);
      end
      enc = encode(got);
      checks++;
      if (enc !== {4'h0, 4'(i)}) begin
        failures++;
        $display("[TB] FAIL roundtrip idx=%0d: got %h expected %h", i, enc, 8'(i));
      end
    end
  endtask

  task automatic test_accumulate();
    logic [15:0] got;
    logic [15:0] exp;
    logic [3:0]  seq [4];
    seq = '{4'd0, 4'd5, 4'd15, 4'd5};
    send_event(4'd0, 1'b0, 1'b1);
    settle(1);
    exp = next_expected();
    checks++;
    got = dut_mask();
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL acc_preclear: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      send_event(seq[i], 1'b1, 1'b0);
      settle(1);
      exp = next_expected();
      checks++;
      got = dut_mask();
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL acc_step%0d: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (got !== 16'h8021) begin
      failures++;
      $display("[TB] FAIL acc_total: got %h expected 8021", got);
    end
    send_event(4'd3, 1'b1, 1'b1);
    settle(1);
    exp = next_expected();
    checks++;
    got = dut_mask();
    if (got !== exp || got !== 16'h8021) begin
      failures++;
      $display("[TB] FAIL acc_none_keep: got %h expected 8021", got);
    end
    send_event(4'd3, 1'b0, 1'b1);
    settle(1);
    exp = next_expected();
    checks++;
    got = dut_mask();
    if (got !== exp || got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL replace_none_clear: got %h expected 0000", got);
    end
  endtask

  task automatic test_held_strobe();
    logic [15:0] got;
    logic [15:0] exp;
    dut_if.ui_in = 8'h07;
    settle(1);
    dut_if.ui_in = 8'h17;
    model_mask = model_next(model_mask, 4'd7, 1'b0, 1'b0);
    exp_q.push_back(model_mask);
    settle(3);
    exp = next_expected();
    checks++;
    got = dut_mask();
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL held_first: got %h expected %h", got, exp);
    end
    settle(7);
    dut_if.ui_in = 8'h12;
    settle(6);
    checks++;
    got = dut_mask();
    if (got !== 16'h0080) begin
      failures++;
      $display("[TB] FAIL held_no_retrigger: got %h expected 0080", got);
    end
    dut_if.ui_in = 8'h02;
    settle(4);
  endtask

  task automatic test_clear_vs_event();
    logic [15:0] got;
    for (int i = 0; i < 16; i++) begin
      send_event(4'(i), 1'b1, 1'b0);
      settle(1);
      void'(next_expected());
    end
    checks++;
    got = dut_mask();
    if (got !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL clr_build: got %h expected ffff", got);
    end
    dut_if.ui_in = 8'h24;
    settle(1);
    dut_if.ui_in = 8'h74;
    model_mask = 16'h0000;
    settle(3);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL clr_wins: got %h expected 0000", got);
    end
    dut_if.ui_in = 8'h34;
    settle(5);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL clr_edge_consumed: got %h expected 0000", got);
    end
    dut_if.ui_in = 8'h24;
    settle(3);
  endtask

  task automatic test_reset_mid_acc();
    logic [15:0] got;
    logic [15:0] exp;
    send_event(4'd0, 1'b0, 1'b1);
    settle(1);
    void'(next_expected());
    for (int i = 4; i < 8; i++) begin
      send_event(4'(i), 1'b1, 1'b0);
      settle(1);
      exp = next_expected();
    end
    checks++;
    got = dut_mask();
    if (got !== 16'h00F0 || exp !== 16'h00F0) begin
      failures++;
      $display("[TB] FAIL mid_build: got %h expected 00f0", got);
    end
    dut_if.ui_in = 8'h29;
    rst_n = 1'b0;
    settle(1);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_reset: got %h expected 0000", got);
    end
    rst_n = 1'b1;
    model_mask = 16'h0000;
    settle(6);
    checks++;
    got = dut_mask();
    if (got !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL mid_no_spurious: got %h expected 0000", got);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    model_mask   = 16'h0000;
    prev_mask    = 16'h0000;
    rst_n        = 1'b0;
    dut_if.ena    = 1'b1;
    dut_if.uio_in = 8'h00;
    dut_if.ui_in  = 8'hFF;
    test_reset();
    test_replace_sweep();
    test_accumulate();
    test_held_strobe();
    test_clear_vs_event();
    test_reset_mid_acc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
